// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: halts the core and streams x0..x(NUM_REGS-1) from read port 1 over valid/ready
module reg_dump_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              cpu_halted_i,
    output logic              halt_req_o,
    output logic              rf_sel_o,
    output logic [4:0]        rf_rR_o,
    input  logic [DATA_W-1:0] rf_rD_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [4:0]        dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    typedef enum logic [2:0] {IDLE, HALT_WAIT, READ, SEND, DONE} state_t;

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = 1'b0;
        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i && !abort_i) begin
                    state_d = HALT_WAIT;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                HALT_WAIT: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cpu_halted_i) begin
                        state_d = READ;
                    end else if (cnt_d == 8'(TIMEOUT)) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
                READ: if (!cpu_halted_i) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    data_d  = rf_rD_i;
                    state_d = SEND;
                end
                SEND: if (!cpu_halted_i) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (dump_ready_i) begin
                    state_d = (idx_q == 5'(NUM_REGS - 1)) ? DONE : READ;
                    idx_d   = (idx_q == 5'(NUM_REGS - 1)) ? idx_q : idx_q + 5'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy_o       = state_q != IDLE;
    assign halt_req_o   = state_q != IDLE;
    assign rf_sel_o     = state_q == READ;
    assign rf_rR_o      = rf_sel_o ? idx_q : '0;
    assign dump_valid_o = state_q == SEND;
    assign dump_addr_o  = dump_valid_o ? idx_q : '0;
    assign dump_data_o  = dump_valid_o ? data_q : '0;
    assign done_o       = state_q == DONE;
    assign err_o        = err_q;
endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb_reg_dump_ctrl: directed vector table plus hand-written dump sequences for reg_dump_ctrl
module tb_reg_dump_ctrl;
    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0, abort_i = 1'b0, cpu_halted_i = 1'b0, dump_ready_i = 1'b0;
    logic        halt_req_o, rf_sel_o, dump_valid_o, busy_o, done_o, err_o;
    logic [4:0]  rf_rR_o, dump_addr_o;
    logic [31:0] rf_rD_i, dump_data_o;
    logic [31:0] regs [32];
    int          errors = 0, checks = 0;

    typedef struct {
        logic        st, ab, hl, rd;
        logic [47:0] ex;
    } vec_t;
    vec_t tbl[$];

    always #5 clk_i = ~clk_i;
    assign rf_rD_i = regs[rf_rR_o];

    reg_dump_ctrl #(.NUM_REGS(32), .DATA_W(32), .TIMEOUT(10)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .abort_i(abort_i),
        .cpu_halted_i(cpu_halted_i), .halt_req_o(halt_req_o), .rf_sel_o(rf_sel_o),
        .rf_rR_o(rf_rR_o), .rf_rD_i(rf_rD_i), .dump_valid_o(dump_valid_o),
        .dump_ready_i(dump_ready_i), .dump_addr_o(dump_addr_o), .dump_data_o(dump_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    function automatic logic [47:0] outs();
        return {busy_o, halt_req_o, rf_sel_o, dump_valid_o, done_o, err_o, rf_rR_o, dump_addr_o, dump_data_o};
    endfunction

    function automatic logic [47:0] e(logic b, logic s, logic v, logic d, logic er, logic [4:0] rr, logic [4:0] a, logic [31:0] dat);
        return {b, b, s, v, d, er, rr, a, dat};
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic begin_dump();
        cpu_halted_i = 1'b0;
        start_i = 1'b1;
        tick();
        chk("hw_halt_req", 64'(halt_req_o), 64'd1);
        start_i = 1'b0;
        tick();
        tick();
        cpu_halted_i = 1'b1;
        tick();
        chk("read_sel", 64'(rf_sel_o), 64'd1);
    endtask

    task automatic collect(input int stall_word, input int stall_len, input int start_word);
        int words = 0, dones = 0, stalled = 0, done_at = -1;
        bit fin = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            start_i = 1'b0;
            if (done_o) begin
                dones++;
                if (done_at < 0) done_at = c;
            end
            if (!busy_o) fin = 1;
            else if (dump_valid_o) begin
                chk($sformatf("word%0d_addr", words), 64'(dump_addr_o), 64'(words));
                chk($sformatf("word%0d_data", words), 64'(dump_data_o), 64'(regs[words[4:0]]));
                if (words == stall_word && stalled < stall_len) begin
                    dump_ready_i = 1'b0;
                    stalled++;
                end else begin
                    dump_ready_i = 1'b1;
                    words++;
                end
                if (words == start_word) start_i = 1'b1;
            end
            if (!fin) tick();
        end
        start_i = 1'b0;
        chk("dump_finished", 64'(fin), 64'd1);
        chk("word_count", 64'(words), 64'd32);
        chk("stall_cycles", 64'(stalled), 64'(stall_len));
        chk("done_pulses", 64'(dones), 64'd1);
        chk("done_cycle", 64'(done_at), 64'(64 + stall_len));
        chk("halt_req_after", 64'(halt_req_o), 64'd0);
    endtask

    task automatic run_to_word(input int w);
        bit found = 0;
        dump_ready_i = 1'b1;
        for (int c = 0; c < 200 && !found; c++) begin
            if (dump_valid_o && dump_addr_o == 5'(w)) found = 1;
            else tick();
        end
        chk($sformatf("reach_word%0d", w), 64'(found), 64'd1);
    endtask

    initial begin
        foreach (regs[i]) regs[i] = '0;
        regs[3]  = 32'h12345678;
        regs[31] = 32'hDEADBEEF;
        #1;
        chk("reset_outs", 64'(outs()), 64'd0);
        #20;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();
        chk("idle_outs", 64'(outs()), 64'd0);

        tbl.push_back('{1, 1, 0, 0, 48'h0});
        tbl.push_back('{1, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{0, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{0, 0, 1, 0, e(1, 1, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{0, 0, 1, 0, e(1, 0, 1, 0, 0, 0, 0, 0)});
        tbl.push_back('{0, 0, 1, 0, e(1, 0, 1, 0, 0, 0, 0, 0)});
        tbl.push_back('{0, 0, 1, 1, e(1, 1, 0, 0, 0, 1, 0, 0)});
        tbl.push_back('{0, 0, 1, 0, e(1, 0, 1, 0, 0, 0, 1, 0)});
        tbl.push_back('{0, 0, 1, 1, e(1, 1, 0, 0, 0, 2, 0, 0)});
        tbl.push_back('{0, 0, 1, 1, e(1, 0, 1, 0, 0, 0, 2, 0)});
        tbl.push_back('{0, 0, 1, 1, e(1, 1, 0, 0, 0, 3, 0, 0)});
        for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 1, 0, e(1, 0, 1, 0, 0, 0, 3, 32'h12345678)});
        tbl.push_back('{0, 0, 1, 1, e(1, 1, 0, 0, 0, 4, 0, 0)});
        tbl.push_back('{1, 0, 1, 0, e(1, 0, 1, 0, 0, 0, 4, 0)});
        tbl.push_back('{0, 1, 1, 1, 48'h0});
        tbl.push_back('{1, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{0, 1, 0, 0, 48'h0});
        tbl.push_back('{1, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{0, 0, 1, 0, e(1, 1, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{0, 0, 0, 0, e(0, 0, 0, 0, 1, 0, 0, 0)});
        tbl.push_back('{0, 0, 0, 0, 48'h0});
        foreach (tbl[i]) begin
            start_i = tbl[i].st;
            abort_i = tbl[i].ab;
            cpu_halted_i = tbl[i].hl;
            dump_ready_i = tbl[i].rd;
            tick();
            chk($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].ex));
        end
        {start_i, abort_i, cpu_halted_i, dump_ready_i} = 4'b0;
        tick();

        begin_dump();
        collect(-1, 0, 10);
        tick();
        begin_dump();
        collect(3, 5, -1);
        tick();

        begin
            int n = 0;
            bit seen_valid = 0;
            cpu_halted_i = 1'b0;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            while (n < 50 && !err_o) begin
                tick();
                n++;
                if (dump_valid_o) seen_valid = 1;
            end
            chk("timeout_cycles", 64'(n), 64'd10);
            chk("timeout_outs", 64'(outs()), 64'(e(0, 0, 0, 0, 1, 0, 0, 0)));
            chk("timeout_no_valid", 64'(seen_valid), 64'd0);
            tick();
            chk("timeout_after", 64'(outs()), 64'd0);
        end

        begin_dump();
        run_to_word(7);
        abort_i = 1'b1;
        tick();
        chk("abort_outs", 64'(outs()), 64'd0);
        abort_i = 1'b0;
        tick();
        begin_dump();
        collect(-1, 0, -1);
        tick();

        begin_dump();
        run_to_word(12);
        cpu_halted_i = 1'b0;
        tick();
        chk("drop_outs", 64'(outs()), 64'(e(0, 0, 0, 0, 1, 0, 0, 0)));
        tick();
        chk("drop_after", 64'(outs()), 64'd0);

        begin_dump();
        run_to_word(5);
        #3;
        reset_n_i = 1'b0;
        #1;
        chk("async_reset_outs", 64'(outs()), 64'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        cpu_halted_i = 1'b0;
        tick();
        chk("post_reset_idle", 64'(outs()), 64'd0);
        begin_dump();
        collect(-1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_dump_ctrl.md
Name: reg_dump_ctrl

Overview:
- Debug scanner that borrows register-file read port 1 to stream the whole register file (x0..x31) to the on-board display/UART path over a valid/ready handshake.
- Requests a core halt, waits for the acknowledge, then reads one register per visit and presents {addr, data} until the downstream consumer accepts it.
- Sits between the core control unit (halt handshake), the read-port-1 address mux in front of the register file, and the debug output sink.

Parameters:
- NUM_REGS, 32, number of registers scanned, indices 0..NUM_REGS-1; range 2..32.
- DATA_W, 32, register data width.
- TIMEOUT, 255, maximum cycles spent in HALT_WAIT before giving up; range 1..255 (8-bit counter).

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort_i  in  1  cancels a dump in progress; wins over every other event.
- cpu_halted_i  in  1  core acknowledges that it is stalled and will not write the register file.
- halt_req_o  out  1  stall request to the core.
- rf_sel_o  out  1  1 = this block drives read-port-1 address; 0 = core drives it.
- rf_rR_o  out  5  read address to the register file, zero-extended index.
- rf_rD_i  in  DATA_W  combinational read data from read port 1.
- dump_valid_o  out  1  {dump_addr_o, dump_data_o} is valid.
- dump_ready_i  in  1  sink accepts the current word.
- dump_addr_o  out  5  register index of the current word.
- dump_data_o  out  DATA_W  register value of the current word.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a dump completes.
- err_o  out  1  one-cycle pulse on halt timeout, or on loss of halt mid-dump.

Behaviour:
- Reset, asynchronous, with reset_n_i=0:
  - state=IDLE, idx=0, timeout counter=0, data register=0.
  - All outputs 0, including rf_rR_o, dump_addr_o and dump_data_o.
- States: IDLE, HALT_WAIT, READ, SEND, DONE. All outputs are registered or decoded from state only (Moore).
- IDLE:
  - start_i=1 and abort_i=0 -> HALT_WAIT; clear idx and the timeout counter.
  - start_i together with abort_i -> stay in IDLE.
- HALT_WAIT:
  - halt_req_o=1; counter increments each cycle.
  - cpu_halted_i=1 -> READ.
  - Otherwise, counter reaching TIMEOUT -> IDLE with err_o pulsed for 1 cycle.
  - cpu_halted_i takes priority over timeout in the same cycle.
- READ, exactly 1 cycle:
  - rf_sel_o=1, rf_rR_o=idx.
  - rf_rD_i is captured into the data register at the clock edge -> SEND.
  - x0 reads as 0 through the register file; the captured value is passed through unmodified.
- SEND:
  - dump_valid_o=1, dump_addr_o=idx, dump_data_o=captured value; all three are held stable while dump_ready_i=0.
  - On valid&&ready: if idx==NUM_REGS-1 -> DONE; otherwise idx+1 -> READ.
  - rf_sel_o=0 in SEND, so the port is returned to the core between reads.
- DONE, 1 cycle: done_o=1, halt_req_o=1 -> IDLE. halt_req_o falls on entry to IDLE.
- halt_req_o=1 in HALT_WAIT, READ, SEND and DONE; busy_o=1 in the same states.
- Throughput: 2 cycles per register minimum (READ+SEND). A full 32-register dump takes 64 cycles + halt latency + 1 (DONE).
- abort_i=1 in any non-IDLE state -> IDLE next edge:
  - dump_valid_o drops even if no handshake completed; a word may be lost on abort.
  - No done_o, no err_o.
  - abort takes priority over ready, halt acknowledge and timeout.
- cpu_halted_i=0 while in READ or SEND -> IDLE with err_o pulse; a word being offered in SEND is withdrawn.
- start_i while busy_o=1 is ignored and is not queued.
- Reset mid-dump: immediate return to the reset values; halt_req_o drops asynchronously.
- idx never wraps: the DONE transition occurs at NUM_REGS-1.

Test Plan:
- Regs preloaded x3=0x12345678, x31=0xDEADBEEF, others 0; start_i pulse, cpu_halted_i 2 cycles after halt_req_o, dump_ready_i=1 -> 32 words in order with addr 0..31; word 3 = 0x12345678, word 31 = 0xDEADBEEF, word 0 = 0; done_o pulses once 64 cycles after the halt ack; halt_req_o=0 the following cycle.
- Same preload with dump_ready_i low for 5 cycles on word 3 -> dump_valid_o, addr=3 and data=0x12345678 held for all 5 cycles; no duplicate or skipped words.
- cpu_halted_i never asserted with TIMEOUT=10 -> err_o pulses exactly 10 cycles after entry to HALT_WAIT; busy_o=0 and halt_req_o=0 afterwards; no dump_valid_o.
- abort_i asserted while in SEND on word 7 -> next cycle state IDLE, dump_valid_o=0, halt_req_o=0, done_o=0, err_o=0; a new start_i then dumps from x0.
- cpu_halted_i dropped during word 12 -> err_o pulse, return to IDLE; start_i pulsed while busy during a normal dump -> ignored, exactly 32 words emitted.
- reset_n_i pulsed low mid-dump (off-edge) -> all outputs 0 immediately; normal operation resumes after release.
